// File: rtl/code_stretch_dec_pkg.sv
// -----------------------------------------------------------------------------
// code_stretch_dec_pkg
//   Shared definitions for the code_stretch_dec block:
//     - FSM state encoding (IDLE / HOLD / GAP) as plain localparams so the
//       encoding stays visible to legacy tools and waveform viewers
//     - hold/gap counter width and its type
//     - onehot4(): 2-bit code to 4-bit one-hot line decode
// -----------------------------------------------------------------------------
package code_stretch_dec_pkg;

  // Hold/gap counter width. Wide enough for the full 1..255 cycle range.
  localparam int CNT_W = 8;

  typedef logic [CNT_W-1:0] cnt_t;

  // FSM state encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  // Decode a 2-bit code into the matching one-hot line.
  function automatic logic [3:0] onehot4(input logic [1:0] code);
    onehot4 = 4'b0001 << code;
  endfunction

endpackage

// File: rtl/code_stretch_dec_if.sv
// -----------------------------------------------------------------------------
// code_stretch_dec_if
//   Bundle of the request handshake and strobe outputs of code_stretch_dec.
//   Signal names follow the block's published pin names.
//
//   Signals
//     EN          decoder enable, active-high
//     CODE_VALID  source presents a code on CODEin
//     CODEin[1:0] code to decode (0..3)
//     CODE_READY  decoder accepts CODEin this cycle
//     DECout[3:0] registered one-hot strobe
//     BUSY        decoder in HOLD or GAP
//     DROP        one-cycle pulse: a code was discarded
//
//   Modports
//     master  request source / downstream side (drives EN, CODE_VALID, CODEin)
//     slave   the decoder itself
// -----------------------------------------------------------------------------
interface code_stretch_dec_if;

  logic       EN;
  logic       CODE_VALID;
  logic [1:0] CODEin;
  logic       CODE_READY;
  logic [3:0] DECout;
  logic       BUSY;
  logic       DROP;

  modport master (
    output EN,
    output CODE_VALID,
    output CODEin,
    input  CODE_READY,
    input  DECout,
    input  BUSY,
    input  DROP
  );

  modport slave (
    input  EN,
    input  CODE_VALID,
    input  CODEin,
    output CODE_READY,
    output DECout,
    output BUSY,
    output DROP
  );

endinterface

// File: rtl/code_stretch_dec_cyc_down_counter.sv
// -----------------------------------------------------------------------------
// cyc_down_counter
//   Loadable down counter that times the HOLD and GAP phases. It saturates at
//   zero instead of wrapping; the owner reloads it for every new phase.
//
//   Ports
//     clk       system clock, rising-edge
//     rst_n     asynchronous active-low reset (count -> 0)
//     clr       synchronous clear to 0 (highest priority)
//     load      load load_val (beats dec)
//     load_val  value loaded on load
//     dec       decrement by one, ignored once the count is 0
//     zero      count is 0
// -----------------------------------------------------------------------------
module cyc_down_counter
  import code_stretch_dec_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic load,
  input  cnt_t load_val,
  input  logic dec,
  output logic zero
);

  cnt_t count;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - cnt_t'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/code_stretch_dec.sv
// -----------------------------------------------------------------------------
// code_stretch_dec
//   Receive-side partner of a 4-to-2 priority encoder. A 2-bit code accepted
//   over a valid/ready handshake is turned into a registered one-hot strobe
//   held for HOLD_CYC cycles, followed by GAP_CYC forced all-zero cycles.
//
//   Parameters
//     HOLD_CYC  cycles each strobe stays asserted (1..255)
//     GAP_CYC   all-zero cycles after each strobe (0..255)
//
//   Ports
//     CLK    system clock, rising-edge
//     RST_N  asynchronous active-low reset
//     bus    code_stretch_dec_if.slave: EN, CODE_VALID, CODEin, CODE_READY,
//            DECout, BUSY, DROP
//
//   Build option
//     DEC_SKID_EN  when defined, adds a one-entry skid register so a second
//                  code can be accepted during HOLD/GAP and launched
//                  back-to-back at the end of the current strobe. Undefined
//                  (default): CODE_READY is low for the whole HOLD/GAP.
//
//   A code accepted while EN is low is discarded and DROP pulses for one
//   cycle. EN dropping during HOLD/GAP returns to IDLE on the next edge and
//   discards any queued code (again with a DROP pulse).
// -----------------------------------------------------------------------------
module code_stretch_dec
  import code_stretch_dec_pkg::*;
#(
  parameter int unsigned HOLD_CYC = 4,
  parameter int unsigned GAP_CYC  = 1
) (
  input  logic                CLK,
  input  logic                RST_N,
  code_stretch_dec_if.slave   bus
);

  // Counter reload values: a phase of N cycles runs the counter N-1 .. 0.
  localparam cnt_t HOLD_LOAD = cnt_t'(HOLD_CYC - 1);
  localparam cnt_t GAP_LOAD  = cnt_t'(GAP_CYC - 1);

  logic [1:0] state_q,  state_d;
  logic [1:0] code_q,   code_d;
  logic [3:0] dec_q,    dec_d;
  logic       drop_q,   drop_d;

  logic       ready;
  logic       xfer;

  logic       cnt_clr;
  logic       cnt_load;
  cnt_t       cnt_load_val;
  logic       cnt_dec;
  logic       cnt_zero;

`ifdef DEC_SKID_EN
  logic       skid_valid_q, skid_valid_d;
  logic [1:0] skid_code_q,  skid_code_d;

  // Accept while idle, or while busy as long as the skid slot is free.
  assign ready = (state_q == ST_IDLE) || !skid_valid_q;
`else
  assign ready = (state_q == ST_IDLE);
`endif

  assign xfer = bus.CODE_VALID && ready;

  // ---------------------------------------------------------------------------
  // Hold/gap timer
  // ---------------------------------------------------------------------------
  cyc_down_counter u_cnt (
    .clk      (CLK),
    .rst_n    (RST_N),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d      = state_q;
    code_d       = code_q;
    drop_d       = 1'b0;
    cnt_clr      = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = HOLD_LOAD;
    cnt_dec      = 1'b0;
`ifdef DEC_SKID_EN
    skid_valid_d = skid_valid_q;
    skid_code_d  = skid_code_q;
    // A code accepted while busy parks in the skid slot; the end-of-strobe
    // and EN-low paths below override this where it matters.
    if (xfer && (state_q != ST_IDLE)) begin
      skid_valid_d = 1'b1;
      skid_code_d  = bus.CODEin;
    end
`endif

    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          if (bus.EN) begin
            code_d   = bus.CODEin;
            cnt_load = 1'b1;
            state_d  = ST_HOLD;
          end else begin
            drop_d = 1'b1;
          end
        end
      end

      ST_HOLD, ST_GAP: begin
        if (!bus.EN) begin
          // Abort: back to IDLE, timer cleared, queued work thrown away.
          state_d = ST_IDLE;
          cnt_clr = 1'b1;
`ifdef DEC_SKID_EN
          drop_d       = skid_valid_q || xfer;
          skid_valid_d = 1'b0;
`endif
        end else if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else if ((state_q == ST_HOLD) && (GAP_CYC != 0)) begin
          state_d      = ST_GAP;
          cnt_load     = 1'b1;
          cnt_load_val = GAP_LOAD;
        end else begin
          // End of strobe.
`ifdef DEC_SKID_EN
          if (skid_valid_q) begin
            code_d       = skid_code_q;
            cnt_load     = 1'b1;
            state_d      = ST_HOLD;
            skid_valid_d = 1'b0;
          end else if (xfer) begin
            // Code arriving on the very last cycle launches straight away.
            code_d       = bus.CODEin;
            cnt_load     = 1'b1;
            state_d      = ST_HOLD;
            skid_valid_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
`else
          state_d = ST_IDLE;
`endif
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_clr = 1'b1;
      end
    endcase

    // DECout is registered: it shows the strobe for the state being entered.
    dec_d = (state_d == ST_HOLD) ? onehot4(code_d) : 4'b0000;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      // NOTE: the latched code is reset as well even though it only matters
      // in HOLD; it keeps the register deterministic right after reset.
      code_q  <= 2'd0;
      dec_q   <= 4'b0000;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      dec_q   <= dec_d;
      drop_q  <= drop_d;
    end
  end

`ifdef DEC_SKID_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      skid_valid_q <= 1'b0;
      skid_code_q  <= 2'd0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_code_q  <= skid_code_d;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.CODE_READY = ready;
  assign bus.DECout     = dec_q;
  assign bus.BUSY       = (state_q != ST_IDLE);
  assign bus.DROP       = drop_q;

endmodule

// File: tb/tb_code_stretch_dec.sv
// -----------------------------------------------------------------------------
// tb_code_stretch_dec
//   Directed bench for code_stretch_dec. Two instances share clock and reset:
//     dut_a  HOLD_CYC=4, GAP_CYC=1
//     dut_b  HOLD_CYC=2, GAP_CYC=0
//   Expected per-cycle outputs are queued when stimulus is driven and popped
//   one entry per instance at each clock edge (#1 after the edge).
//   Compile with +define+DEC_SKID_EN to cover the skid build.
// -----------------------------------------------------------------------------
module tb_code_stretch_dec;

`ifdef DEC_SKID_EN
  localparam logic SKID = 1'b1;
`else
  localparam logic SKID = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  code_stretch_dec_if if_a ();
  code_stretch_dec_if if_b ();

  code_stretch_dec #(.HOLD_CYC(4), .GAP_CYC(1)) dut_a (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (if_a)
  );

  code_stretch_dec #(.HOLD_CYC(2), .GAP_CYC(0)) dut_b (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (if_b)
  );

  typedef struct packed {
    logic [3:0] dec;
    logic       busy;
    logic       ready;
    logic       drop;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];

  int total = 0;
  int bad   = 0;

  function automatic exp_t mk(logic [3:0] d, logic b, logic r, logic p);
    exp_t e;
    e.dec   = d;
    e.busy  = b;
    e.ready = r;
    e.drop  = p;
    return e;
  endfunction

  task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_now(string tag, bit which, exp_t e);
    exp_t o;
    if (which) o = {if_b.DECout, if_b.BUSY, if_b.CODE_READY, if_b.DROP};
    else       o = {if_a.DECout, if_a.BUSY, if_a.CODE_READY, if_a.DROP};
    check({tag, ".dec"},   {4'b0, o.dec},   {4'b0, e.dec});
    check({tag, ".busy"},  {7'b0, o.busy},  {7'b0, e.busy});
    check({tag, ".ready"}, {7'b0, o.ready}, {7'b0, e.ready});
    check({tag, ".drop"},  {7'b0, o.drop},  {7'b0, e.drop});
  endtask

  task automatic push(bit which, exp_t e);
    if (which) sb_b.push_back(e);
    else       sb_a.push_back(e);
  endtask

  // Reference model of one accepted code: hold cycles, gap cycles, then idle.
  task automatic push_strobe(bit which, logic [1:0] code, int hold, int gap,
                             logic rdy_busy);
    logic [3:0] oh;
    oh = 4'b0001 << code;
    for (int i = 0; i < hold; i++) push(which, mk(oh, 1'b1, rdy_busy, 1'b0));
    for (int i = 0; i < gap; i++)  push(which, mk(4'b0000, 1'b1, rdy_busy, 1'b0));
    push(which, mk(4'b0000, 1'b0, 1'b1, 1'b0));
  endtask

  task automatic tick(string tag);
    @(posedge clk);
    #1;
    if (sb_a.size() > 0) check_now({tag, "/a"}, 1'b0, sb_a.pop_front());
    if (sb_b.size() > 0) check_now({tag, "/b"}, 1'b1, sb_b.pop_front());
  endtask

  task automatic tick_n(string tag, int n);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  task automatic drive(bit which, logic en, logic valid, logic [1:0] code);
    if (which) begin
      if_b.EN = en; if_b.CODE_VALID = valid; if_b.CODEin = code;
    end else begin
      if_a.EN = en; if_a.CODE_VALID = valid; if_a.CODEin = code;
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 2'd0);
    drive(1'b1, 1'b0, 1'b0, 2'd0);

    // Reset state.
    #2;
    check_now("reset", 1'b0, mk(4'b0000, 1'b0, 1'b1, 1'b0));
    check_now("reset", 1'b1, mk(4'b0000, 1'b0, 1'b1, 1'b0));
    #6 rst_n = 1'b1;

    // Code 2: 0100 for 4 cycles, one gap cycle, ready on the 6th cycle.
    // CODEin changes after the transfer must not disturb the strobe.
    drive(1'b0, 1'b1, 1'b1, 2'd2);
    push_strobe(1'b0, 2'd2, 4, 1, SKID);
    tick("basic");
    drive(1'b0, 1'b1, 1'b0, 2'd0);
    tick_n("basic", 5);

    // EN low: code discarded, single DROP pulse, no strobe.
    drive(1'b0, 1'b0, 1'b1, 2'd3);
    push(1'b0, mk(4'b0000, 1'b0, 1'b1, 1'b1));
    push(1'b0, mk(4'b0000, 1'b0, 1'b1, 1'b0));
    tick("drop_en0");
    drive(1'b0, 1'b0, 1'b0, 2'd0);
    tick("drop_en0");

    // Code 1 accepted, EN falls in the 2nd HOLD cycle -> IDLE next edge.
    drive(1'b0, 1'b1, 1'b1, 2'd1);
    push(1'b0, mk(4'b0010, 1'b1, SKID, 1'b0));
    push(1'b0, mk(4'b0010, 1'b1, SKID, 1'b0));
    push(1'b0, mk(4'b0000, 1'b0, 1'b1, 1'b0));
    push(1'b0, mk(4'b0000, 1'b0, 1'b1, 1'b0));
    tick("en_abort");
    drive(1'b0, 1'b1, 1'b0, 2'd1);
    tick("en_abort");
    drive(1'b0, 1'b0, 1'b0, 2'd1);
    tick_n("en_abort", 2);
    drive(1'b0, 1'b1, 1'b0, 2'd0);

`ifndef DEC_SKID_EN
    // Valid held: code 0 then 3, one idle cycle between strobes.
    drive(1'b0, 1'b1, 1'b1, 2'd0);
    push_strobe(1'b0, 2'd0, 4, 1, 1'b0);
    tick("held");
    drive(1'b0, 1'b1, 1'b1, 2'd3);
    tick_n("held", 5);
    push_strobe(1'b0, 2'd3, 4, 1, 1'b0);
    tick("held");
    drive(1'b0, 1'b1, 1'b0, 2'd0);
    tick_n("held", 5);

    // GAP_CYC=0 instance: 0001 x2, idle, 1000 x2, idle.
    drive(1'b1, 1'b1, 1'b1, 2'd0);
    push_strobe(1'b1, 2'd0, 2, 0, 1'b0);
    tick("gap0");
    drive(1'b1, 1'b1, 1'b1, 2'd3);
    tick_n("gap0", 2);
    push_strobe(1'b1, 2'd3, 2, 0, 1'b0);
    tick("gap0");
    drive(1'b1, 1'b1, 1'b0, 2'd0);
    tick_n("gap0", 2);
`else
    // Skid: codes 1,2 back-to-back with no idle cycle; code 3 stalls until
    // the skid slot empties at the launch of code 2.
    drive(1'b0, 1'b1, 1'b1, 2'd1);
    push(1'b0, mk(4'b0010, 1'b1, 1'b1, 1'b0));
    tick("skid");
    drive(1'b0, 1'b1, 1'b1, 2'd2);
    push(1'b0, mk(4'b0010, 1'b1, 1'b0, 1'b0));
    tick("skid");
    drive(1'b0, 1'b1, 1'b1, 2'd3);
    for (int i = 0; i < 2; i++) push(1'b0, mk(4'b0010, 1'b1, 1'b0, 1'b0));
    push(1'b0, mk(4'b0000, 1'b1, 1'b0, 1'b0));
    push(1'b0, mk(4'b0100, 1'b1, 1'b1, 1'b0));
    push(1'b0, mk(4'b0100, 1'b1, 1'b0, 1'b0));
    tick_n("skid", 5);
    drive(1'b0, 1'b1, 1'b0, 2'd0);
    for (int i = 0; i < 2; i++) push(1'b0, mk(4'b0100, 1'b1, 1'b0, 1'b0));
    push(1'b0, mk(4'b0000, 1'b1, 1'b0, 1'b0));
    push_strobe(1'b0, 2'd3, 4, 1, 1'b1);
    tick_n("skid", 9);

    // Skid: EN falls with a queued code -> IDLE and DROP pulse.
    drive(1'b0, 1'b1, 1'b1, 2'd1);
    push(1'b0, mk(4'b0010, 1'b1, 1'b1, 1'b0));
    tick("skid_abort");
    drive(1'b0, 1'b1, 1'b1, 2'd2);
    push(1'b0, mk(4'b0010, 1'b1, 1'b0, 1'b0));
    tick("skid_abort");
    drive(1'b0, 1'b0, 1'b0, 2'd0);
    push(1'b0, mk(4'b0000, 1'b0, 1'b1, 1'b1));
    push(1'b0, mk(4'b0000, 1'b0, 1'b1, 1'b0));
    tick_n("skid_abort", 2);
    drive(1'b0, 1'b1, 1'b0, 2'd0);
`endif

    // Asynchronous reset in the middle of a strobe.
    drive(1'b0, 1'b1, 1'b1, 2'd1);
    push(1'b0, mk(4'b0010, 1'b1, SKID, 1'b0));
    push(1'b0, mk(4'b0010, 1'b1, SKID, 1'b0));
    tick("rst_mid");
    drive(1'b0, 1'b1, 1'b0, 2'd0);
    tick("rst_mid");
    rst_n = 1'b0;
    #1;
    check_now("rst_async", 1'b0, mk(4'b0000, 1'b0, 1'b1, 1'b0));
    #2 rst_n = 1'b1;
    push(1'b0, mk(4'b0000, 1'b0, 1'b1, 1'b0));
    tick("rst_release");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
